// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_mux_if
// Description : Bundle for display_scan_mux. Carries the value/load/blanking
//               controls into the scanner and the nibble, anode enables,
//               slot index and frame pulse out of it.
//   i_Valor        4*N_DIGITS  value to show, digit 0 in bits [3:0]
//   i_Cargar       1           one-cycle load strobe
//   i_Blank_Ceros  1           leading-zero blanking enable
//   o_Nibble       4           nibble for the 7-segment decoder
//   o_Anodos       N_DIGITS    digit enables
//   o_Digito       3           current slot index
//   o_Frame        1           pulse when the slot index wraps to 0
//   Modports: master = value source / display side, slave = scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] i_Valor;
  logic                  i_Cargar;
  logic                  i_Blank_Ceros;
  logic [3:0]            o_Nibble;
  logic [N_DIGITS-1:0]   o_Anodos;
  logic [2:0]            o_Digito;
  logic                  o_Frame;

  modport master (
    output i_Valor, i_Cargar, i_Blank_Ceros,
    input  o_Nibble, o_Anodos, o_Digito, o_Frame
  );

  modport slave (
    input  i_Valor, i_Cargar, i_Blank_Ceros,
    output o_Nibble, o_Anodos, o_Digito, o_Frame
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_mux
// Description : Time-multiplexes an N-digit hex value onto a shared segment
//               bus. Loads are frame-synchronous (shadow -> display register
//               at the wrap to slot 0), each slot opens with DEAD_CYCLES of
//               all-anodes-off, and leading zeros can be blanked.
//   i_Clk    : system clock
//   i_Reset  : synchronous active-high reset
//   bus      : display_scan_mux_if.slave (value, load, blank in;
//              nibble, anodes, slot index, frame pulse out)
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_mux #(
  parameter int N_DIGITS         = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int DEAD_CYCLES      = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  wire logic         i_Clk,
  input  wire logic         i_Reset,
  display_scan_mux_if.slave bus
);

  localparam int c_PW = $clog2(REFRESH_DIV);
  localparam int c_IW = $clog2(N_DIGITS);
  localparam int c_W  = 4 * N_DIGITS;

  localparam logic [c_PW-1:0]     c_PRESC_LAST = c_PW'(REFRESH_DIV - 1);
  localparam logic [c_IW-1:0]     c_IDX_LAST   = c_IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] c_ANODES_OFF = {N_DIGITS{ANODE_ACTIVE_LOW}};

  typedef enum logic {
    SLOT_DEAD = 1'b0,
    SLOT_ON   = 1'b1
  } slot_e;

  logic [c_PW-1:0]     presc_q,  presc_d;
  logic [c_IW-1:0]     idx_q,    idx_d;
  logic [c_W-1:0]      shadow_q, shadow_d;
  logic [c_W-1:0]      disp_q,   disp_d;
  logic                pend_q,   pend_d;
  logic [3:0]          nibble_q, nibble_d;
  logic [N_DIGITS-1:0] anodes_q, anodes_d;
  logic                frame_q,  frame_d;

  logic                w_wrap;
  logic                w_frame_wrap;
  logic                w_dead;
  slot_e               w_slot;
  logic [3:0]          w_digits [N_DIGITS];
  logic [N_DIGITS-1:0] w_blanked;
  logic                w_upper_zero;
  logic [N_DIGITS-1:0] w_en;

  // Prescaler and slot index
  always_comb begin
    w_wrap       = (presc_q == c_PRESC_LAST);
    w_frame_wrap = w_wrap && (idx_q == c_IDX_LAST);
    presc_d      = w_wrap ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    if (w_wrap) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_d = w_frame_wrap;
  end

  // Load path. A strobe on the frame-wrap edge bypasses the shadow so the
  // new value is visible in the frame that is just starting.
  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (bus.i_Cargar && w_frame_wrap) begin
      disp_d = bus.i_Valor;
      pend_d = 1'b0;
    end else if (bus.i_Cargar) begin
      shadow_d = bus.i_Valor;
      pend_d   = 1'b1;
    end else if (w_frame_wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so that nibble, index and
  // anodes all update on the same edge.
  generate
    if (DEAD_CYCLES > 0) begin : g_dead
      assign w_dead = (presc_d < c_PW'(DEAD_CYCLES));
    end else begin : g_no_dead
      assign w_dead = 1'b0;
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      w_digits[k] = disp_d[4*k +: 4];
    end
  end

  // Digit k > 0 is blanked when it and every digit above it are zero.
  always_comb begin
    w_blanked    = '0;
    w_upper_zero = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      w_upper_zero = w_upper_zero && (w_digits[k] == 4'h0);
      w_blanked[k] = bus.i_Blank_Ceros && w_upper_zero;
    end
  end

  always_comb begin
    w_slot   = w_dead ? SLOT_DEAD : SLOT_ON;
    w_en     = '0;
    nibble_d = w_digits[idx_d];
    if ((w_slot == SLOT_ON) && !w_blanked[idx_d]) begin
      w_en[idx_d] = 1'b1;
    end
    anodes_d = ANODE_ACTIVE_LOW ? ~w_en : w_en;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      nibble_q <= 4'h0;
      anodes_q <= c_ANODES_OFF;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      nibble_q <= nibble_d;
      anodes_q <= anodes_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.o_Nibble = nibble_q;
  assign bus.o_Anodos = anodes_q;
  assign bus.o_Digito = 3'(idx_q);
  assign bus.o_Frame  = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_mux
// Description : Directed self-checking bench for display_scan_mux with
//               N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, active-low anodes.
//               A 16-cycle frame: phase p -> slot p/4, prescaler p%4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_mux_if #(.N_DIGITS(4)) bus_if ();

  display_scan_mux #(
    .N_DIGITS        (4),
    .REFRESH_DIV     (4),
    .DEAD_CYCLES     (1),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // cycles since reset release; phase = cyc % 16

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advance_to(input int ph);
    for (int k = 0; k < 16 && (cyc % 16) != ph; k++) step();
  endtask

  // Expected nibble: digit of the current slot
  function automatic logic [3:0] f_nib(input logic [15:0] v, input int ph);
    int i;
    i = (ph % 16) / 4;
    return v[i*4 +: 4];
  endfunction

  // Expected anodes: off in the first (dead) cycle of a slot or if blanked
  function automatic logic [3:0] f_an(input logic [15:0] v, input bit blk, input int ph);
    int         i;
    logic       blanked;
    logic [3:0] oh;
    i       = (ph % 16) / 4;
    blanked = blk && (i > 0) && ((v >> (4*i)) == 16'h0);
    oh      = 4'b0001 << i;
    if ((ph % 4) == 0 || blanked) return 4'hF;
    return ~oh;
  endfunction

  task automatic test_reset();
    int ph;
    rst = 1'b1;
    bus_if.i_Valor = 16'h0; bus_if.i_Cargar = 1'b0; bus_if.i_Blank_Ceros = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (bus_if.o_Anodos !== 4'hF || bus_if.o_Nibble !== 4'h0 ||
          bus_if.o_Digito !== 3'd0 || bus_if.o_Frame !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%b nib=%h dig=%0d fr=%b required an=1111 nib=0 dig=0 fr=0",
                 bus_if.o_Anodos, bus_if.o_Nibble, bus_if.o_Digito, bus_if.o_Frame);
      end
    end
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      ph = cyc % 16;
      checks++;
      if (bus_if.o_Nibble !== 4'h0 || bus_if.o_Anodos !== f_an(16'h0, 1'b0, ph) ||
          bus_if.o_Digito !== 3'(ph/4) || bus_if.o_Frame !== (ph == 0)) begin
        errors++;
        $display("FAIL after_reset cyc=%0d nib=%h an=%b dig=%0d fr=%b required an=%b dig=%0d fr=%b",
                 cyc, bus_if.o_Nibble, bus_if.o_Anodos, bus_if.o_Digito, bus_if.o_Frame,
                 f_an(16'h0, 1'b0, ph), ph/4, (ph == 0));
      end
    end
  endtask

  task automatic test_load_frame();
    int ph;
    advance_to(0);
    bus_if.i_Valor = 16'h1A3F; bus_if.i_Cargar = 1'b1;
    step();
    bus_if.i_Cargar = 1'b0; bus_if.i_Valor = 16'h0;
    advance_to(0);
    for (int k = 0; k < 16; k++) begin
      ph = cyc % 16;
      checks++;
      if (bus_if.o_Nibble !== f_nib(16'h1A3F, ph) || bus_if.o_Anodos !== f_an(16'h1A3F, 1'b0, ph) ||
          bus_if.o_Digito !== 3'(ph/4) || bus_if.o_Frame !== (ph == 0)) begin
        errors++;
        $display("FAIL load_frame ph=%0d nib=%h/%h an=%b/%b dig=%0d fr=%b (actual/required)",
                 ph, bus_if.o_Nibble, f_nib(16'h1A3F, ph), bus_if.o_Anodos,
                 f_an(16'h1A3F, 1'b0, ph), bus_if.o_Digito, bus_if.o_Frame);
      end
      step();
    end
  endtask

  task automatic test_last_wins();
    int ph;
    advance_to(0);
    bus_if.i_Valor = 16'h1234; bus_if.i_Cargar = 1'b1;
    step();
    bus_if.i_Cargar = 1'b0;
    advance_to(0);
    advance_to(8);
    bus_if.i_Valor = 16'h5678; bus_if.i_Cargar = 1'b1;
    step();
    bus_if.i_Cargar = 1'b0; bus_if.i_Valor = 16'h0;
    // Phases 9..11 then 12 (where the second strobe goes in) then 13..15
    for (int k = 0; k < 8 && !(k > 0 && (cyc % 16) == 0); k++) begin
      ph = cyc % 16;
      if (ph == 12) begin
        bus_if.i_Valor = 16'h9ABC; bus_if.i_Cargar = 1'b1;
      end
      checks++;
      if (bus_if.o_Nibble !== f_nib(16'h1234, ph) || bus_if.o_Anodos !== f_an(16'h1234, 1'b0, ph)) begin
        errors++;
        $display("FAIL old_frame_held ph=%0d nib=%h/%h an=%b/%b (actual/required)",
                 ph, bus_if.o_Nibble, f_nib(16'h1234, ph), bus_if.o_Anodos, f_an(16'h1234, 1'b0, ph));
      end
      step();
      bus_if.i_Cargar = 1'b0;
    end
    bus_if.i_Valor = 16'h0;
    for (int k = 0; k < 16; k++) begin
      ph = cyc % 16;
      checks++;
      if (bus_if.o_Nibble !== f_nib(16'h9ABC, ph) || bus_if.o_Anodos !== f_an(16'h9ABC, 1'b0, ph) ||
          bus_if.o_Frame !== (ph == 0)) begin
        errors++;
        $display("FAIL last_wins ph=%0d nib=%h/%h an=%b/%b fr=%b (actual/required)",
                 ph, bus_if.o_Nibble, f_nib(16'h9ABC, ph), bus_if.o_Anodos,
                 f_an(16'h9ABC, 1'b0, ph), bus_if.o_Frame);
      end
      step();
    end
  endtask

  task automatic test_bypass();
    int ph;
    advance_to(15);
    bus_if.i_Valor = 16'h00F0; bus_if.i_Cargar = 1'b1;
    step();
    bus_if.i_Cargar = 1'b0; bus_if.i_Valor = 16'h0;
    for (int k = 0; k < 32; k++) begin
      ph = cyc % 16;
      checks++;
      if (bus_if.o_Nibble !== f_nib(16'h00F0, ph) || bus_if.o_Anodos !== f_an(16'h00F0, 1'b0, ph) ||
          bus_if.o_Digito !== 3'(ph/4)) begin
        errors++;
        $display("FAIL bypass k=%0d ph=%0d nib=%h/%h an=%b/%b dig=%0d (actual/required)",
                 k, ph, bus_if.o_Nibble, f_nib(16'h00F0, ph), bus_if.o_Anodos,
                 f_an(16'h00F0, 1'b0, ph), bus_if.o_Digito);
      end
      step();
    end
  endtask

  task automatic test_blanking();
    int          ph;
    logic [15:0] vals [3];
    vals = '{16'h0050, 16'h0000, 16'h0500};
    bus_if.i_Blank_Ceros = 1'b1;
    for (int j = 0; j < 3; j++) begin
      advance_to(0);
      bus_if.i_Valor = vals[j]; bus_if.i_Cargar = 1'b1;
      step();
      bus_if.i_Cargar = 1'b0; bus_if.i_Valor = 16'h0;
      advance_to(0);
      for (int k = 0; k < 16; k++) begin
        ph = cyc % 16;
        checks++;
        if (bus_if.o_Nibble !== f_nib(vals[j], ph) || bus_if.o_Anodos !== f_an(vals[j], 1'b1, ph)) begin
          errors++;
          $display("FAIL blanking val=%h ph=%0d nib=%h/%h an=%b/%b (actual/required)",
                   vals[j], ph, bus_if.o_Nibble, f_nib(vals[j], ph), bus_if.o_Anodos,
                   f_an(vals[j], 1'b1, ph));
        end
        step();
      end
    end
    bus_if.i_Blank_Ceros = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ph;
    advance_to(0);
    bus_if.i_Valor = 16'h7777; bus_if.i_Cargar = 1'b1;
    step();
    bus_if.i_Cargar = 1'b0; bus_if.i_Valor = 16'h0;
    advance_to(9);
    rst = 1'b1;
    step();
    checks++;
    if (bus_if.o_Anodos !== 4'hF || bus_if.o_Nibble !== 4'h0 ||
        bus_if.o_Digito !== 3'd0 || bus_if.o_Frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid an=%b nib=%h dig=%0d fr=%b required an=1111 nib=0 dig=0 fr=0",
               bus_if.o_Anodos, bus_if.o_Nibble, bus_if.o_Digito, bus_if.o_Frame);
    end
    rst = 1'b0;
    cyc = 0;
    // Display must be 0 and the aborted load must not appear at the wrap.
    for (int k = 0; k < 16; k++) begin
      step();
      ph = cyc % 16;
      checks++;
      if (bus_if.o_Nibble !== 4'h0 || bus_if.o_Anodos !== f_an(16'h0, 1'b0, ph) ||
          bus_if.o_Digito !== 3'(ph/4) || bus_if.o_Frame !== (ph == 0)) begin
        errors++;
        $display("FAIL reset_mid_after cyc=%0d nib=%h an=%b/%b dig=%0d fr=%b (actual/required)",
                 cyc, bus_if.o_Nibble, bus_if.o_Anodos, f_an(16'h0, 1'b0, ph),
                 bus_if.o_Digito, bus_if.o_Frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_last_wins();
    test_bypass();
    test_blanking();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
